// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - ALUCTRL codes, FSM encoding and helpers for muldiv_unit
package muldiv_unit_pkg;

    localparam logic [4:0] ALUCTRL_NOP    = 5'd0;
    localparam logic [4:0] ALUCTRL_ADD    = 5'd1;
    localparam logic [4:0] ALUCTRL_SUB    = 5'd2;
    localparam logic [4:0] ALUCTRL_AND    = 5'd3;
    localparam logic [4:0] ALUCTRL_OR     = 5'd4;
    localparam logic [4:0] ALUCTRL_XOR    = 5'd5;
    localparam logic [4:0] ALUCTRL_SLL    = 5'd6;
    localparam logic [4:0] ALUCTRL_SRL    = 5'd7;
    localparam logic [4:0] ALUCTRL_SRA    = 5'd8;
    localparam logic [4:0] ALUCTRL_SLT    = 5'd9;
    localparam logic [4:0] ALUCTRL_SLTU   = 5'd10;
    localparam logic [4:0] ALUCTRL_MUL    = 5'd16;
    localparam logic [4:0] ALUCTRL_MULH   = 5'd17;
    localparam logic [4:0] ALUCTRL_MULHSU = 5'd18;
    localparam logic [4:0] ALUCTRL_MULHU  = 5'd19;
    localparam logic [4:0] ALUCTRL_DIV    = 5'd20;
    localparam logic [4:0] ALUCTRL_DIVU   = 5'd21;
    localparam logic [4:0] ALUCTRL_REM    = 5'd22;
    localparam logic [4:0] ALUCTRL_REMU   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    function automatic int iter_cnt_w(input int bits);
        return $clog2(bits) + 1;
    endfunction

    function automatic logic is_mul_code(input logic [4:0] code);
        return (code == ALUCTRL_MUL) || (code == ALUCTRL_MULH) ||
               (code == ALUCTRL_MULHSU) || (code == ALUCTRL_MULHU);
    endfunction

    function automatic logic is_div_code(input logic [4:0] code);
        return (code == ALUCTRL_DIV) || (code == ALUCTRL_DIVU) ||
               (code == ALUCTRL_REM) || (code == ALUCTRL_REMU);
    endfunction

    function automatic logic op_a_signed(input logic [4:0] code);
        return (code == ALUCTRL_MUL) || (code == ALUCTRL_MULH) ||
               (code == ALUCTRL_MULHSU) || (code == ALUCTRL_DIV) ||
               (code == ALUCTRL_REM);
    endfunction

    function automatic logic op_b_signed(input logic [4:0] code);
        return (code == ALUCTRL_MUL) || (code == ALUCTRL_MULH) ||
               (code == ALUCTRL_DIV) || (code == ALUCTRL_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - operation/result handshake bundle between execute stage and muldiv_unit
interface muldiv_unit_if #(
    parameter int BITS = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      alu_ctrl;
    logic [BITS-1:0] op_a;
    logic [BITS-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] result;

    modport master (
        output flush, in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  flush, in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/muldiv_iter_datapath.sv
// rtl/muldiv_iter_datapath.sv - shift-add multiply / restoring divide iteration registers
module muldiv_iter_datapath #(
    parameter int BITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_div,
    input  logic [BITS-1:0]   i_a_mag,
    input  logic [BITS-1:0]   i_b_mag,
    output logic [2*BITS-1:0] o_acc,
    output logic              o_mul_last
);
    logic [2*BITS-1:0] r_acc;
    logic [2*BITS-1:0] r_mcand;
    logic [BITS-1:0]   r_mplier;

    logic [BITS:0]     w_rem_sh;
    logic [BITS:0]     w_diff;
    logic [2*BITS-1:0] w_mul_sum;

    // Divide: r_acc = {remainder, dividend/quotient}; divisor sits in r_mcand low word.
    assign w_rem_sh  = {r_acc[2*BITS-1:BITS], r_acc[BITS-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_mcand[BITS-1:0]};
    assign w_mul_sum = r_acc + (r_mplier[0] ? r_mcand : {(2*BITS){1'b0}});

    assign o_acc      = r_acc;
    assign o_mul_last = ~|r_mplier[BITS-1:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_load) begin
            if (i_div) begin
                r_acc    <= {{BITS{1'b0}}, i_a_mag};
                r_mcand  <= {{BITS{1'b0}}, i_b_mag};
                r_mplier <= '0;
            end else begin
                r_acc    <= '0;
                r_mcand  <= {{BITS{1'b0}}, i_a_mag};
                r_mplier <= i_b_mag;
            end
        end else if (i_step) begin
            if (i_div) begin
                if (!w_diff[BITS]) begin
                    r_acc <= {w_diff[BITS-1:0], r_acc[BITS-2:0], 1'b1};
                end else begin
                    r_acc <= {w_rem_sh[BITS-1:0], r_acc[BITS-2:0], 1'b0};
                end
            end else begin
                r_acc    <= w_mul_sum;
                r_mcand  <= {r_mcand[2*BITS-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[BITS-1:1]};
            end
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with valid/ready handshake
// Optional build macro: MULDIV_EARLY_OUT_EN (multiply CALC stops when remaining multiplier bits are zero)
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = iter_cnt_w(BITS);

    muldiv_state_e     r_state;
    muldiv_state_e     w_next;
    logic [4:0]        r_code;
    logic              r_sign_a;
    logic              r_sign_b;
    logic [CNT_W-1:0]  r_cnt;
    logic [BITS-1:0]   r_result;
    logic              r_out_valid;

    logic              w_accept;
    logic              w_is_mul_in;
    logic              w_is_div_in;
    logic              w_sa_in;
    logic              w_sb_in;
    logic [BITS-1:0]   w_a_mag;
    logic [BITS-1:0]   w_b_mag;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic [BITS-1:0]   w_special_res;
    logic              w_dp_div;
    logic              w_dp_load;
    logic              w_dp_step;
    logic [2*BITS-1:0] w_dp_acc;
    logic              w_dp_mul_last;
    logic              w_calc_last;
    logic [2*BITS-1:0] w_prod;
    logic [BITS-1:0]   w_quot;
    logic [BITS-1:0]   w_rem;
    logic [BITS-1:0]   w_fix_res;
    logic              w_out_hs;

    assign w_accept    = (r_state == ST_IDLE) && bus.in_valid && !bus.flush;
    assign w_is_mul_in = is_mul_code(bus.alu_ctrl);
    assign w_is_div_in = is_div_code(bus.alu_ctrl);
    assign w_sa_in     = bus.op_a[BITS-1] && op_a_signed(bus.alu_ctrl);
    assign w_sb_in     = bus.op_b[BITS-1] && op_b_signed(bus.alu_ctrl);
    assign w_a_mag     = w_sa_in ? -bus.op_a : bus.op_a;
    assign w_b_mag     = w_sb_in ? -bus.op_b : bus.op_b;

    assign w_div_zero  = w_is_div_in && (bus.op_b == '0);
    assign w_ovf       = ((bus.alu_ctrl == ALUCTRL_DIV) || (bus.alu_ctrl == ALUCTRL_REM)) &&
                         (bus.op_a == {1'b1, {(BITS-1){1'b0}}}) && (bus.op_b == {BITS{1'b1}});
    assign w_special   = w_div_zero || w_ovf || !(w_is_mul_in || w_is_div_in);

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            if ((bus.alu_ctrl == ALUCTRL_DIV) || (bus.alu_ctrl == ALUCTRL_DIVU)) begin
                w_special_res = {BITS{1'b1}};
            end else begin
                w_special_res = bus.op_a;
            end
        end else if (w_ovf && (bus.alu_ctrl == ALUCTRL_DIV)) begin
            w_special_res = {1'b1, {(BITS-1){1'b0}}};
        end
    end

    assign w_dp_load = w_accept && !w_special;
    assign w_dp_step = (r_state == ST_CALC);
    assign w_dp_div  = w_accept ? w_is_div_in : is_div_code(r_code);

    muldiv_iter_datapath #(
        .BITS(BITS)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_dp_load),
        .i_step    (w_dp_step),
        .i_div     (w_dp_div),
        .i_a_mag   (w_a_mag),
        .i_b_mag   (w_b_mag),
        .o_acc     (w_dp_acc),
        .o_mul_last(w_dp_mul_last)
    );

`ifdef MULDIV_EARLY_OUT_EN
    assign w_calc_last = (r_cnt == CNT_W'(BITS-1)) || (is_mul_code(r_code) && w_dp_mul_last);
`else
    assign w_calc_last = (r_cnt == CNT_W'(BITS-1));
    logic w_unused_mul_last;
    assign w_unused_mul_last = w_dp_mul_last;
`endif

    assign w_prod = (r_sign_a ^ r_sign_b) ? -w_dp_acc : w_dp_acc;
    assign w_quot = (r_sign_a ^ r_sign_b) ? -w_dp_acc[BITS-1:0] : w_dp_acc[BITS-1:0];
    assign w_rem  = r_sign_a ? -w_dp_acc[2*BITS-1:BITS] : w_dp_acc[2*BITS-1:BITS];

    always_comb begin
        w_fix_res = '0;
        case (r_code)
            ALUCTRL_MUL:                                     w_fix_res = w_prod[BITS-1:0];
            ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU:     w_fix_res = w_prod[2*BITS-1:BITS];
            ALUCTRL_DIV, ALUCTRL_DIVU:                       w_fix_res = w_quot;
            ALUCTRL_REM, ALUCTRL_REMU:                       w_fix_res = w_rem;
            default:                                         w_fix_res = '0;
        endcase
    end

    // No accept in the handshake cycle: DONE returns to IDLE first.
    assign w_out_hs = r_out_valid && bus.out_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = w_special ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (bus.flush)        w_next = ST_IDLE;
                else if (w_calc_last) w_next = ST_FIX;
            end
            ST_FIX:  w_next = bus.flush ? ST_IDLE : ST_DONE;
            ST_DONE: if (bus.flush || w_out_hs) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_code      <= '0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_out_valid <= (r_state == ST_DONE) && !bus.flush && !w_out_hs;
            if (w_accept) begin
                r_code   <= bus.alu_ctrl;
                r_sign_a <= w_sa_in;
                r_sign_b <= w_sb_in;
                r_cnt    <= '0;
                if (w_special) r_result <= w_special_res;
            end else if (r_state == ST_CALC) begin
                r_cnt <= r_cnt + 1'b1;
            end else if ((r_state == ST_FIX) && !bus.flush) begin
                r_result <= w_fix_res;
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.BITS(32)) bus ();

    muldiv_unit #(.BITS(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic int lat_mul(input logic [31:0] bmag);
`ifdef MULDIV_EARLY_OUT_EN
        int it = 1;
        for (int i = 0; i < 32; i++) if (bmag[i]) it = i + 1;
        return it + 2;
`else
        if (bmag == 32'hx) return 0;
        return 34;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int hold);
        int   lat;
        logic seen;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = code;
        bus.op_a     = a;
        bus.op_b     = b;
        chk({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.alu_ctrl = ALUCTRL_NOP;
        bus.op_a     = ~a;
        bus.op_b     = ~b;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            seen = bus.out_valid;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, bus.result, exp_res);
        chk({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_result"}, bus.result, exp_res);
            chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic seen;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_ctrl  = ALUCTRL_NOP;
        bus.op_a      = '0;
        bus.op_b      = '0;
        #2;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul_7_m3",   ALUCTRL_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, lat_mul(32'd3), 0);
        run_op("mulhu_m1",   ALUCTRL_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, lat_mul(32'hFFFFFFFF), 0);
        run_op("mulhsu_m1",  ALUCTRL_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, lat_mul(32'hFFFFFFFF), 0);
        run_op("mulh_m1",    ALUCTRL_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, lat_mul(32'd1), 0);
        run_op("mul_9_1",    ALUCTRL_MUL,    32'd9,        32'd1,        32'd9,        lat_mul(32'd1), 0);
        run_op("div_m7_2",   ALUCTRL_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0);
        run_op("rem_m7_2",   ALUCTRL_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0);
        run_op("divu_100_7", ALUCTRL_DIVU,   32'd100,      32'd7,        32'h0000000E, 34, 10);
        run_op("remu_100_7", ALUCTRL_REMU,   32'd100,      32'd7,        32'h00000002, 34, 0);
        run_op("div_5_0",    ALUCTRL_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1, 0);
        run_op("rem_5_0",    ALUCTRL_REM,    32'd5,        32'd0,        32'h00000005, 1, 0);
        run_op("div_ovf",    ALUCTRL_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        run_op("rem_ovf",    ALUCTRL_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0);
        run_op("non_m_add",  ALUCTRL_ADD,    32'd5,        32'd6,        32'h00000000, 1, 0);

        // flush during the fifth CALC cycle
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = ALUCTRL_MULHU;
        bus.op_a     = 32'hFFFFFFFF;
        bus.op_b     = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_calc_idle", 32'(bus.in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("flush_calc_no_valid", 32'(seen), 32'd0);

        // in_valid together with flush in IDLE is not accepted
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.alu_ctrl = ALUCTRL_DIV;
        bus.op_a     = 32'd5;
        bus.op_b     = 32'd0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        chk("flush_idle_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("flush_idle_no_valid", 32'(seen), 32'd0);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = ALUCTRL_MULHU;
        bus.op_a     = 32'hFFFFFFFF;
        bus.op_b     = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_result", bus.result, 32'd0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_op("mul_3_4", ALUCTRL_MUL, 32'd3, 32'd4, 32'h0000000C, lat_mul(32'd4), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
